// File: rtl/mem_axi_data_if_pkg.sv
// Shared definitions for the MEM-stage data-side AXI master.
//   MEM_SIZE_*      : access size codes carried from the EX/MEM register
//   AXI_ID_DEFAULT  : default ID for arid/awid/wid
//   AXI_BURST_INCR  : burst type driven on arburst/awburst
//   state_e         : bus FSM states
package mem_axi_data_if_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    localparam logic [3:0] AXI_ID_DEFAULT = 4'h1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/mem_axi_data_if_align.sv
// Combinational data formatting for the MEM-stage bus master.
//   size_i    : access size (byte/half/word)
//   sign_i    : sign-extend narrow loads
//   off_i     : byte offset, addr[1:0]
//   st_data_i : right-justified store data
//   rd_data_i : raw AXI read data
//   wstrb_o   : byte strobes for the W channel
//   wdata_o   : store data replicated onto every lane
//   ld_data_o : selected lane, zero- or sign-extended
module mem_axi_data_if_align
    import mem_axi_data_if_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rd_data_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    // Requested lane shifted down to bit 0; for words the offset is 0.
    logic [31:0] lane;
    assign lane = rd_data_i >> {off_i, 3'b000};

    always_comb begin
        wstrb_o   = 4'b1111;
        wdata_o   = st_data_i;
        ld_data_o = lane;
        case (size_i)
            MEM_SIZE_B: begin
                wstrb_o   = 4'b0001 << off_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = {{24{sign_i & lane[7]}}, lane[7:0]};
            end
            MEM_SIZE_H: begin
                wstrb_o   = 4'b0011 << off_i;
                wdata_o   = {2{st_data_i[15:0]}};
                ld_data_o = {{16{sign_i & lane[15]}}, lane[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_axi_data_if.sv
// MEM-stage data-side bus master: runs each load/store from EX/MEM as a
// single-beat AXI transaction, stalls the pipeline until it completes and
// returns aligned/extended load data.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   exception             : pipeline flush; the current access is discarded
//   mem_req/we/size/sign/addr/wdata : access request from EX/MEM
//   mem_rdata             : registered load result
//   data_stall            : hold the pipeline
//   ar*/r*/aw*/w*/b*      : AXI master channels (len=0, INCR, wlast=1)
// Build option: define DATA_POSTED_WRITE_EN to let stores complete once AW
// and W are accepted, with the B response tracked by pending_b.
module mem_axi_data_if
    import mem_axi_data_if_pkg::*;
#(
    parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exception,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              data_stall,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;
    logic [31:0]         st_data_q, st_data_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                drop_q, drop_d;

    logic                req_live;
    logic                issue_ok;
    logic                dropping;
    logic                busy;
    logic [31:0]         ld_data;
    logic [3:0]          fmt_wstrb;
    logic [31:0]         fmt_wdata;

    mem_axi_data_if_align u_align (
        .size_i    (size_q),
        .sign_i    (sign_q),
        .off_i     (addr_q[1:0]),
        .st_data_i (st_data_q),
        .rd_data_i (rdata),
        .wstrb_o   (fmt_wstrb),
        .wdata_o   (fmt_wdata),
        .ld_data_o (ld_data)
    );

    // Fixed single-beat transaction attributes.
    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign wid     = AXI_ID;
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = AXI_BURST_INCR;
    assign awburst = AXI_BURST_INCR;
    assign wlast   = 1'b1;

    // Payload comes straight from the registers captured at issue, so it
    // cannot move while a valid is up.
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign awsize  = {1'b0, size_q};
    assign wdata   = fmt_wdata;
    assign wstrb   = fmt_wstrb;
    assign mem_rdata = rdata_q;

    assign arvalid = (state_q == ST_RD_ADDR);
    assign rready  = (state_q == ST_RD_DATA);
    assign awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
    assign wvalid  = (state_q == ST_WR_REQ) && !w_done_q;

    assign req_live = mem_req && !exception;
    // A flush seen at any point of a transaction (including the cycle of the
    // final handshake) discards its result.
    assign dropping = drop_q || exception;
    assign busy     = (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA) ||
                      (state_q == ST_WR_REQ)  || (state_q == ST_WR_RESP);
    assign data_stall = ((state_q == ST_IDLE) && req_live) || busy;

`ifdef DATA_POSTED_WRITE_EN
    logic pending_b_q, pending_b_d;
    // A new access waits in IDLE (stalled) while a posted B is outstanding.
    assign issue_ok = req_live && !pending_b_q;
    assign bready   = pending_b_q;
`else
    assign issue_ok = req_live;
    assign bready   = (state_q == ST_WR_RESP);
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        sign_d    = sign_q;
        st_data_d = st_data_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        drop_d    = drop_q;
`ifdef DATA_POSTED_WRITE_EN
        pending_b_d = pending_b_q && !bvalid;
`endif
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (issue_ok) begin
                    addr_d    = mem_addr;
                    size_d    = mem_size;
                    sign_d    = mem_sign;
                    st_data_d = mem_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = mem_we ? ST_WR_REQ : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                drop_d = dropping;
                if (arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                drop_d = dropping;
                if (rvalid) begin
                    drop_d = 1'b0;
                    if (dropping) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdata_d = ld_data;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WR_REQ: begin
                drop_d    = dropping;
                aw_done_d = aw_done_q || (awvalid && awready);
                w_done_d  = w_done_q  || (wvalid && wready);
                if (aw_done_d && w_done_d) begin
`ifdef DATA_POSTED_WRITE_EN
                    pending_b_d = 1'b1;
                    drop_d      = 1'b0;
                    state_d     = dropping ? ST_IDLE : ST_DONE;
`else
                    state_d = ST_WR_RESP;
`endif
                end
            end
            ST_WR_RESP: begin
                drop_d = dropping;
                if (bvalid) begin
                    drop_d  = 1'b0;
                    state_d = dropping ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= MEM_SIZE_W;
            sign_q    <= 1'b0;
            st_data_q <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            st_data_q <= st_data_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            drop_q    <= drop_d;
        end
    end

`ifdef DATA_POSTED_WRITE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_b_q <= 1'b0;
        end else begin
            pending_b_q <= pending_b_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_axi_data_if.sv
// Self-checking bench for mem_axi_data_if: directed cases followed by random
// loads/stores against a programmable-latency AXI slave model.
module tb_mem_axi_data_if;

`ifdef DATA_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk, rst, exception, mem_req, mem_we, mem_sign;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        data_stall;
    logic [3:0]  arid, awid, wid, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;

    mem_axi_data_if dut (
        .clk(clk), .rst(rst), .exception(exception), .mem_req(mem_req),
        .mem_we(mem_we), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .data_stall(data_stall),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Slave latency knobs (cycles a valid/ready waits before the answer).
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] cur_rdata = '0;

    // Slave observations.
    logic [31:0] rec_araddr, rec_awaddr, rec_wdata;
    logic [2:0]  rec_arsize, rec_awsize;
    logic [3:0]  rec_wstrb;
    int aw_hi = 0, w_hi = 0, cyc = 0, ar_valid_cyc = 0, b_hs_cyc = 0;

    // Bench's own record of what mem_rdata must hold.
    logic [31:0] model_rdata = '0;

    // ---------------- AXI slave model ----------------
    initial begin
        int  ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        bit  aw_got, w_got, p_awhs, p_whs, p_bhs;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_got = 0; w_got = 0; p_awhs = 0; p_whs = 0; p_bhs = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rdata = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            rdata = cur_rdata;
            if (rst) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                aw_got = 0; w_got = 0; p_awhs = 0; p_whs = 0; p_bhs = 0;
            end else begin
                if (p_awhs) aw_got = 1;
                if (p_whs)  w_got  = 1;
                if (p_bhs) begin
                    aw_got = 0; w_got = 0; bvalid = 0; b_cnt = 0; b_hs_cyc = cyc;
                end
                if (arvalid) begin
                    if (ar_cnt == 0) ar_valid_cyc = cyc;
                    arready = (ar_cnt >= ar_delay);
                    ar_cnt++;
                    if (arready) begin rec_araddr = araddr; rec_arsize = arsize; end
                end else begin
                    arready = 0; ar_cnt = 0;
                end
                if (rready) begin
                    rvalid = (r_cnt >= r_delay);
                    r_cnt++;
                end else begin
                    rvalid = 0; r_cnt = 0;
                end
                if (awvalid) begin
                    awready = (aw_cnt >= aw_delay);
                    aw_cnt++; aw_hi++;
                    if (awready) begin rec_awaddr = awaddr; rec_awsize = awsize; end
                end else begin
                    awready = 0; aw_cnt = 0;
                end
                if (wvalid) begin
                    wready = (w_cnt >= w_delay);
                    w_cnt++; w_hi++;
                    if (wready) begin rec_wdata = wdata; rec_wstrb = wstrb; end
                end else begin
                    wready = 0; w_cnt = 0;
                end
                if (aw_got && w_got && !bvalid) begin
                    bvalid = (b_cnt >= b_delay);
                    b_cnt++;
                end
                p_awhs = awvalid && awready;
                p_whs  = wvalid && wready;
                p_bhs  = bvalid && bready;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_load(input logic [31:0] rd, input int off,
                                             input int sz, input bit sgn);
        longint unsigned v, mask;
        int nb;
        nb   = 1 << sz;
        v    = 64'(rd) >> (8 * off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (sgn && (((v >> (8 * nb - 1)) & 64'd1) != 0)) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_strb(input int off, input int sz);
        int nb;
        nb = 1 << sz;
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int sz);
        if (sz == 0) return 32'(d[7:0]) * 32'h0101_0101;
        if (sz == 1) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One access: da = AR/AW wait, dw = W wait, dr = R wait, db = B wait.
    // exc_after >= 0 pulses exception (and drops mem_req) once that many
    // stall cycles have been seen.
    task automatic run_one(input string tag, input bit we, input int sz,
                           input logic [31:0] addr, input bit sgn, input logic [31:0] d,
                           input int da, input int dw, input int dr, input int db,
                           input int exc_after, input bit chk_stall);
        int stalls, exp_stalls, mx, off;
        bit done;
        off = int'(addr[1:0]);
        ar_delay = da; aw_delay = da; w_delay = dw; r_delay = dr; b_delay = db;
        cur_rdata = d;
        aw_hi = 0; w_hi = 0;
        @(posedge clk); #1;
        mem_we = we; mem_size = 2'(sz); mem_sign = sgn; mem_addr = addr; mem_wdata = d;
        mem_req = 1'b1;
        stalls = 0; done = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!data_stall) begin done = 1; break; end
            stalls++;
            @(posedge clk); #1;
            exception = (stalls == exc_after);
            if (exception) mem_req = 1'b0;
        end
        check({tag, "_complete"}, 32'(done), 32'd1);
        mx = (da > dw) ? da : dw;
        if (we) exp_stalls = POSTED ? (1 + mx + 1) : (1 + mx + 1 + db + 1);
        else    exp_stalls = 1 + da + 1 + dr + 1;
        if (chk_stall) check({tag, "_stall"}, 32'(stalls), 32'(exp_stalls));
        if (we) begin
            check({tag, "_awaddr"}, rec_awaddr, addr);
            check({tag, "_awsize"}, 32'(rec_awsize), 32'(sz));
            check({tag, "_wdata"}, rec_wdata, exp_wdata(d, sz));
            check({tag, "_wstrb"}, 32'(rec_wstrb), 32'(exp_strb(off, sz)));
            check({tag, "_awvalid_cyc"}, 32'(aw_hi), 32'(da + 1));
            check({tag, "_wvalid_cyc"}, 32'(w_hi), 32'(dw + 1));
        end else begin
            if (exc_after < 0) model_rdata = exp_load(d, off, sz, sgn);
            check({tag, "_araddr"}, rec_araddr, addr);
            check({tag, "_arsize"}, 32'(rec_arsize), 32'(sz));
            check({tag, "_rdata"}, mem_rdata, model_rdata);
        end
        @(posedge clk); #1;
        mem_req = 1'b0; exception = 1'b0;
    endtask

    task automatic drain_b(input string tag);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!bready) break;
        end
        check({tag, "_bdrain"}, 32'(bready), 32'd0);
    endtask

    initial begin
        rst = 1; exception = 0; mem_req = 0; mem_we = 0; mem_size = 2'b10;
        mem_sign = 0; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_arvalid", 32'(arvalid), 0);
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_rready", 32'(rready), 0);
        check("rst_bready", 32'(bready), 0);
        check("rst_stall", 32'(data_stall), 0);
        check("rst_rdata", mem_rdata, 32'h0);

        run_one("lw", 0, 2, 32'h1000_0004, 0, 32'h8765_4321, 0, 0, 0, 0, -1, 1);
        $display("LW  addr=%h rdata=%h", 32'h1000_0004, mem_rdata);
        run_one("lb", 0, 0, 32'h2000_0003, 1, 32'h80AA_BBCC, 0, 0, 0, 0, -1, 1);
        $display("LB  addr=%h rdata=%h", 32'h2000_0003, mem_rdata);
        run_one("lbu", 0, 0, 32'h2000_0003, 0, 32'h80AA_BBCC, 1, 0, 2, 0, -1, 1);
        $display("LBU addr=%h rdata=%h", 32'h2000_0003, mem_rdata);
        run_one("sh", 1, 1, 32'h3000_0002, 0, 32'h0000_BEEF, 3, 0, 0, 0, -1, 1);
        $display("SH  addr=%h wdata=%h wstrb=%b", 32'h3000_0002, rec_wdata, rec_wstrb);
        drain_b("sh");
        run_one("lw_exc", 0, 2, 32'h4000_0008, 0, 32'h1234_5678, 0, 0, 2, 0, 2, 1);
        $display("LW with flush in RD_DATA, rdata=%h", mem_rdata);

        @(posedge clk); #1;
        mem_we = 0; mem_req = 1; exception = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_exc_arvalid", 32'(arvalid), 0);
            check("idle_exc_awvalid", 32'(awvalid), 0);
            check("idle_exc_stall", 32'(data_stall), 0);
            @(posedge clk); #1;
        end
        mem_req = 0; exception = 0;
        $display("request under flush in IDLE, nothing issued");

        run_one("sw_b5", 1, 2, 32'h5000_0000, 0, 32'hCAFE_F00D, 0, 0, 0, 5, -1, 1);
        run_one("lw_after_sw", 0, 2, 32'h5000_0004, 0, 32'h0BAD_BEEF, 0, 0, 0, 0, -1, 0);
        check("ar_after_b", 32'(ar_valid_cyc >= b_hs_cyc), 32'd1);
        $display("SW then LW: B at cycle %0d, arvalid at cycle %0d", b_hs_cyc, ar_valid_cyc);
        drain_b("lw_after_sw");

        for (int n = 0; n < 40; n++) begin
            bit we, sgn;
            int sz, off;
            logic [31:0] addr, d;
            we  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            sz  = $urandom_range(0, 2);
            off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
            addr = ($urandom & 32'hFFFF_FFFC) | 32'(off);
            d    = $urandom;
            run_one($sformatf("rnd%0d", n), we, sz, addr, sgn, d,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), -1, 1);
            $display("rnd%0d we=%0d size=%0d addr=%h data=%h rdata=%h", n, we, sz, addr, d, mem_rdata);
            drain_b($sformatf("rnd%0d", n));
        end

        ar_delay = 20;
        @(posedge clk); #1;
        mem_we = 0; mem_size = 2'b10; mem_addr = 32'h6000_0000; mem_req = 1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1; mem_req = 0;
        @(posedge clk); #1;
        rst = 0;
        model_rdata = '0;
        @(negedge clk);
        check("midrst_arvalid", 32'(arvalid), 0);
        check("midrst_stall", 32'(data_stall), 0);
        check("midrst_rdata", mem_rdata, model_rdata);
        $display("reset during RD_ADDR, bus idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
